// File: rtl/alu_op_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_decoder_if
//  Description : Handshake bundle between fetch/decode, the ALU op decoder,
//                and the execute stage.
//                master = environment side (drives instruction fields and
//                         outReady).
//                slave  = decoder side.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_op_decoder_if #(
    parameter int TAG_WIDTH = 5
);
    // upstream (instruction fields in)
    logic                 inValid;
    logic                 inReady;
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 funct7b5;
    logic [TAG_WIDTH-1:0] inTag;

    // downstream (decoded result out)
    logic                 outValid;
    logic                 outReady;
    logic [2:0]           aluControl;
    logic                 illegal;
    logic [TAG_WIDTH-1:0] outTag;

    modport master (
        output inValid, opcode, funct3, funct7b5, inTag, outReady,
        input  inReady, outValid, aluControl, illegal, outTag
    );

    modport slave (
        input  inValid, opcode, funct3, funct7b5, inTag, outReady,
        output inReady, outValid, aluControl, illegal, outTag
    );
endinterface
`default_nettype wire

// File: rtl/alu_op_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_decoder
//  Description : Registered RV32I aluControl decoder with a 2-entry skid
//                buffer and valid/ready handshakes on both sides.
//                Instructions with no ALU encoding are flagged illegal and
//                carry aluControl 000.
//                Optional feature macro: ALU_OP_DECODER_ILLEGAL_STICKY_EN
//                (adds illegalClr / illegalSeen sticky flag).
//  Revision    : 1.0  initial release
// ============================================================================
module alu_op_decoder #(
    parameter int TAG_WIDTH = 5
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    alu_op_decoder_if.slave bus
`ifdef ALU_OP_DECODER_ILLEGAL_STICKY_EN
    ,
    input  wire logic       illegalClr,
    output logic            illegalSeen
`endif
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // occupancy of the skid buffer
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]           count;
    // head entry drives the outputs directly, so outputs hold when empty
    logic [2:0]           head_alu;
    logic                 head_ill;
    logic [TAG_WIDTH-1:0] head_tag;
    // second entry, only meaningful when count == FULL
    logic [2:0]           skid_alu;
    logic                 skid_ill;
    logic [TAG_WIDTH-1:0] skid_tag;

    logic [2:0]           dec_alu;
    logic                 dec_ill;
    logic                 in_fire;
    logic                 out_fire;

    // inReady depends only on the count register: no path from outReady
    assign bus.inReady    = (count != FULL);
    assign bus.outValid   = (count != EMPTY);
    assign bus.aluControl = head_alu;
    assign bus.illegal    = head_ill;
    assign bus.outTag     = head_tag;

    assign in_fire  = bus.inValid && (count != FULL);
    assign out_fire = (count != EMPTY) && bus.outReady;

    // decode the incoming instruction fields into aluControl / illegal
    always_comb begin
        dec_alu = 3'b000;
        dec_ill = 1'b0;
        case (bus.opcode)
            OP_R, OP_I: begin
                case (bus.funct3)
                    3'b000:  dec_alu = (bus.opcode == OP_R && bus.funct7b5) ? 3'b001 : 3'b000;
                    3'b111:  dec_alu = 3'b010;
                    3'b110:  dec_alu = 3'b011;
                    3'b011:  dec_alu = 3'b100;
                    3'b010:  dec_alu = 3'b101;
                    3'b001:  dec_alu = 3'b110;
                    // srl/srli are encodable, sra/srai are not
                    3'b101: begin
                        if (bus.funct7b5) begin
                            dec_ill = 1'b1;
                        end else begin
                            dec_alu = 3'b111;
                        end
                    end
                    // xor/xori has no ALU encoding
                    default: dec_ill = 1'b1;
                endcase
            end
            OP_LOAD, OP_STORE, OP_JALR, OP_AUIPC, OP_LUI, OP_JAL: dec_alu = 3'b000;
            OP_BRANCH: begin
                case (bus.funct3)
                    3'b000, 3'b001: dec_alu = 3'b001;
                    3'b100, 3'b101: dec_alu = 3'b101;
                    3'b110, 3'b111: dec_alu = 3'b100;
                    default:        dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // skid buffer: head is refilled from input (from empty / pass-through) or from skid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= EMPTY;
            head_alu <= 3'b000;
            head_ill <= 1'b0;
            head_tag <= '0;
            skid_alu <= 3'b000;
            skid_ill <= 1'b0;
            skid_tag <= '0;
        end else begin
            case (count)
                EMPTY: begin
                    if (in_fire) begin
                        head_alu <= dec_alu;
                        head_ill <= dec_ill;
                        head_tag <= bus.inTag;
                        count    <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        head_alu <= dec_alu;
                        head_ill <= dec_ill;
                        head_tag <= bus.inTag;
                    end else if (in_fire) begin
                        skid_alu <= dec_alu;
                        skid_ill <= dec_ill;
                        skid_tag <= bus.inTag;
                        count    <= FULL;
                    end else if (out_fire) begin
                        count    <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        head_alu <= skid_alu;
                        head_ill <= skid_ill;
                        head_tag <= skid_tag;
                        count    <= ONE;
                    end
                end
                default: count <= EMPTY;
            endcase
        end
    end

`ifdef ALU_OP_DECODER_ILLEGAL_STICKY_EN
    // sticky flag: set by draining an illegal entry, set beats clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegalSeen <= 1'b0;
        end else if (out_fire && head_ill) begin
            illegalSeen <= 1'b1;
        end else if (illegalClr) begin
            illegalSeen <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_op_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_op_decoder
//  Description : Self-checking bench for alu_op_decoder. Expected decodes are
//                queued on each input transfer and compared on each output
//                transfer. Optional macro: ALU_OP_DECODER_ILLEGAL_STICKY_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_op_decoder;
    localparam int TAG_WIDTH = 5;

    typedef struct packed {
        logic                 ill;
        logic [2:0]           alu;
        logic [TAG_WIDTH-1:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    alu_op_decoder_if #(.TAG_WIDTH(TAG_WIDTH)) bus ();

`ifdef ALU_OP_DECODER_ILLEGAL_STICKY_EN
    logic illegalClr = 1'b0;
    logic illegalSeen;
`endif

    alu_op_decoder #(.TAG_WIDTH(TAG_WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ALU_OP_DECODER_ILLEGAL_STICKY_EN
        ,
        .illegalClr  (illegalClr),
        .illegalSeen (illegalSeen)
`endif
    );

    // reference decode: {illegal, aluControl}
    function automatic logic [3:0] ref_decode(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        if (op == 7'b0110011 || op == 7'b0010011) begin
            if (f3 == 3'b100) return 4'b1000;
            if (f3 == 3'b101 && f7) return 4'b1000;
            if (f3 == 3'b000) return (op == 7'b0110011 && f7) ? 4'b0001 : 4'b0000;
            case (f3)
                3'b001:  return 4'b0110;
                3'b010:  return 4'b0101;
                3'b011:  return 4'b0100;
                3'b101:  return 4'b0111;
                3'b110:  return 4'b0011;
                3'b111:  return 4'b0010;
                default: return 4'b1000;
            endcase
        end
        if (op == 7'b1100011) begin
            if (f3[2:1] == 2'b00) return 4'b0001;
            if (f3[2:1] == 2'b01) return 4'b1000;
            if (f3[2:1] == 2'b10) return 4'b0101;
            return 4'b0100;
        end
        if (op inside {7'b0000011, 7'b0100011, 7'b1100111, 7'b0010111, 7'b0110111, 7'b1101111})
            return 4'b0000;
        return 4'b1000;
    endfunction

    task automatic set_in(input logic v, input logic [6:0] op, input logic [2:0] f3,
                          input logic f7, input logic [TAG_WIDTH-1:0] tag);
        bus.inValid  = v;
        bus.opcode   = op;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
        bus.inTag    = tag;
    endtask

    task automatic push_exp();
        logic [3:0] r;
        exp_t       e;
        r     = ref_decode(bus.opcode, bus.funct3, bus.funct7b5);
        e.ill = r[3];
        e.alu = r[2:0];
        e.tag = bus.inTag;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        set_in(1'b1, 7'b0110011, 3'b000, 1'b1, 5'd9);
        bus.outReady = 1'b1;
        #1 rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.outValid, bus.aluControl, bus.illegal, bus.outTag, bus.inReady} !==
                {1'b0, 3'b000, 1'b0, 5'd0, 1'b1}) begin
                errors++;
                $display("FAIL reset_state: got v=%b alu=%b ill=%b tag=%0d rdy=%b, want v=0 alu=000 ill=0 tag=0 rdy=1",
                         bus.outValid, bus.aluControl, bus.illegal, bus.outTag, bus.inReady);
            end
`ifdef ALU_OP_DECODER_ILLEGAL_STICKY_EN
            checks++;
            if (illegalSeen !== 1'b0) begin
                errors++;
                $display("FAIL reset_sticky: got illegalSeen=%b, want 0", illegalSeen);
            end
`endif
        end
        @(posedge clk);
        #1;
        bus.inValid = 1'b0;
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_stream();
        logic [6:0] ops  [0:2];
        logic [2:0] f3s  [0:2];
        logic       f7s  [0:2];
        exp_t       e;
        int         popped = 0;
        ops = '{7'b0110011, 7'b0010011, 7'b1100011};
        f3s = '{3'b000, 3'b010, 3'b110};
        f7s = '{1'b1, 1'b0, 1'b1};
        bus.outReady = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k < 3) set_in(1'b1, ops[k], f3s[k], f7s[k], 5'(k + 1));
            else       bus.inValid = 1'b0;
            @(negedge clk);
            checks++;
            if (bus.outValid !== 1'(k >= 1 && k <= 3)) begin
                errors++;
                $display("FAIL stream_valid: cycle %0d got outValid=%b, want %b", k, bus.outValid, 1'(k >= 1 && k <= 3));
            end
            if (bus.inValid && bus.inReady) push_exp();
            if (bus.outValid && bus.outReady) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra: got output alu=%b tag=%0d, want none", bus.aluControl, bus.outTag);
                end else begin
                    e = exp_q.pop_front();
                    popped++;
                    if ({bus.illegal, bus.aluControl, bus.outTag} !== {e.ill, e.alu, e.tag}) begin
                        errors++;
                        $display("FAIL stream_out: got ill=%b alu=%b tag=%0d, want ill=%b alu=%b tag=%0d",
                                 bus.illegal, bus.aluControl, bus.outTag, e.ill, e.alu, e.tag);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (popped != 3) begin
            errors++;
            $display("FAIL stream_count: got %0d outputs, want 3", popped);
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] f3s [0:2];
        logic [6:0] ops [0:2];
        exp_t       e;
        int         popped = 0;
        logic       c_done = 1'b0;
        ops = '{7'b0110011, 7'b0110011, 7'b0010011};
        f3s = '{3'b111, 3'b110, 3'b001};
        bus.outReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, ops[k], f3s[k], 1'b0, 5'(10 + k));
            @(negedge clk);
            checks++;
            if (bus.inReady !== 1'(k < 2)) begin
                errors++;
                $display("FAIL bp_ready: instr %0d got inReady=%b, want %b", k, bus.inReady, 1'(k < 2));
            end
            if (bus.inValid && bus.inReady) push_exp();
            if (k == 2) begin
                checks++;
                if ({bus.outValid, bus.aluControl, bus.outTag} !== {1'b1, 3'b010, 5'd10}) begin
                    errors++;
                    $display("FAIL bp_hold: got v=%b alu=%b tag=%0d, want v=1 alu=010 tag=10",
                             bus.outValid, bus.aluControl, bus.outTag);
                end
            end
            @(posedge clk);
            #1;
        end
        bus.outReady = 1'b1;
        for (int n = 0; n < 10 && (exp_q.size() != 0 || !c_done); n++) begin
            @(negedge clk);
            if (bus.inValid && bus.inReady) begin
                push_exp();
                c_done = 1'b1;
            end
            if (bus.outValid && bus.outReady) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra: got output alu=%b tag=%0d, want none", bus.aluControl, bus.outTag);
                end else begin
                    e = exp_q.pop_front();
                    popped++;
                    if ({bus.illegal, bus.aluControl, bus.outTag} !== {e.ill, e.alu, e.tag}) begin
                        errors++;
                        $display("FAIL bp_out: got ill=%b alu=%b tag=%0d, want ill=%b alu=%b tag=%0d",
                                 bus.illegal, bus.aluControl, bus.outTag, e.ill, e.alu, e.tag);
                    end
                end
            end
            @(posedge clk);
            #1;
            if (c_done) bus.inValid = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (popped != 3 || bus.outValid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got %0d outputs outValid=%b, want 3 outputs outValid=0", popped, bus.outValid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_illegal();
        logic [6:0] ops [0:4];
        logic [2:0] f3s [0:4];
        logic       f7s [0:4];
        exp_t       e;
        int         popped = 0;
        ops = '{7'b0110011, 7'b0110011, 7'b1111111, 7'b0010011, 7'b1100011};
        f3s = '{3'b100, 3'b101, 3'b000, 3'b101, 3'b011};
        f7s = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        bus.outReady = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k < 5) set_in(1'b1, ops[k], f3s[k], f7s[k], 5'(4 + k));
            else       bus.inValid = 1'b0;
            @(negedge clk);
            if (bus.inValid && bus.inReady) push_exp();
            if (bus.outValid && bus.outReady) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL ill_extra: got output alu=%b tag=%0d, want none", bus.aluControl, bus.outTag);
                end else begin
                    e = exp_q.pop_front();
                    popped++;
                    if ({bus.illegal, bus.aluControl, bus.outTag} !== {1'b1, 3'b000, e.tag}) begin
                        errors++;
                        $display("FAIL ill_out: got ill=%b alu=%b tag=%0d, want ill=1 alu=000 tag=%0d",
                                 bus.illegal, bus.aluControl, bus.outTag, e.tag);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (popped != 5) begin
            errors++;
            $display("FAIL ill_count: got %0d outputs, want 5", popped);
        end
    endtask

    task automatic test_random();
        logic [6:0] op_list [0:13];
        exp_t       e;
        int         sent = 0;
        int         popped = 0;
        int         n = 0;
        op_list = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b0110011, 7'b0010011, 7'b1100011,
                    7'b0000011, 7'b0100011, 7'b1100111, 7'b0010111, 7'b0110111, 7'b1101111,
                    7'b1111111, 7'b0001111};
        while ((sent < 60 || exp_q.size() != 0) && n < 400) begin
            n++;
            if (sent < 60) begin
                set_in(1'($urandom_range(0, 3) != 0), op_list[$urandom_range(0, 13)],
                       3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), TAG_WIDTH'(sent));
                bus.outReady = 1'($urandom_range(0, 2) != 0);
            end else begin
                bus.inValid  = 1'b0;
                bus.outReady = 1'b1;
            end
            @(negedge clk);
            if (bus.inValid && bus.inReady) begin
                push_exp();
                sent++;
            end
            if (bus.outValid && bus.outReady) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra: got output alu=%b tag=%0d, want none", bus.aluControl, bus.outTag);
                end else begin
                    e = exp_q.pop_front();
                    popped++;
                    if ({bus.illegal, bus.aluControl, bus.outTag} !== {e.ill, e.alu, e.tag}) begin
                        errors++;
                        $display("FAIL rand_out: got ill=%b alu=%b tag=%0d, want ill=%b alu=%b tag=%0d",
                                 bus.illegal, bus.aluControl, bus.outTag, e.ill, e.alu, e.tag);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        bus.inValid = 1'b0;
        checks++;
        if (popped != 60 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_count: got %0d outputs (%0d pending), want 60 (0 pending)", popped, exp_q.size());
        end
    endtask

    task automatic test_midop_reset();
        bus.outReady = 1'b0;
        for (int k = 0; k < 2; k++) begin
            set_in(1'b1, 7'b0110011, 3'b000, 1'(k), 5'(20 + k));
            @(negedge clk);
            if (bus.inValid && bus.inReady) push_exp();
            @(posedge clk);
            #1;
        end
        bus.inValid = 1'b0;
        checks++;
        if ({bus.outValid, bus.inReady} !== 2'b10) begin
            errors++;
            $display("FAIL mid_full: got outValid=%b inReady=%b, want 1 0", bus.outValid, bus.inReady);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.outValid, bus.inReady} !== 2'b01) begin
            errors++;
            $display("FAIL mid_async: got outValid=%b inReady=%b, want 0 1", bus.outValid, bus.inReady);
        end
        exp_q.delete();
        rst_n = 1'b1;
        bus.outReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (bus.outValid !== 1'b0) begin
                errors++;
                $display("FAIL mid_after: cycle %0d got outValid=%b tag=%0d, want 0", k, bus.outValid, bus.outTag);
            end
        end
        @(posedge clk);
        #1;
    endtask

`ifdef ALU_OP_DECODER_ILLEGAL_STICKY_EN
    task automatic test_sticky();
        bus.outReady = 1'b1;
        illegalClr   = 1'b0;
        for (int r = 0; r < 2; r++) begin
            set_in(1'b1, 7'b0110011, 3'b100, 1'b0, 5'(30 + r));
            @(posedge clk);
            #1;
            bus.inValid = 1'b0;
            illegalClr  = 1'(r == 1);
            @(negedge clk);
            checks++;
            if ({bus.outValid, bus.illegal} !== 2'b11) begin
                errors++;
                $display("FAIL sticky_present: round %0d got outValid=%b illegal=%b, want 1 1", r, bus.outValid, bus.illegal);
            end
            @(posedge clk);
            #1;
            illegalClr = 1'b0;
            checks++;
            if (illegalSeen !== 1'b1) begin
                errors++;
                $display("FAIL sticky_set: round %0d got illegalSeen=%b, want 1", r, illegalSeen);
            end
        end
        illegalClr = 1'b1;
        @(posedge clk);
        #1;
        illegalClr = 1'b0;
        checks++;
        if (illegalSeen !== 1'b0) begin
            errors++;
            $display("FAIL sticky_clear: got illegalSeen=%b, want 0", illegalSeen);
        end
    endtask
`endif

    initial begin
        set_in(1'b0, 7'b0, 3'b0, 1'b0, '0);
        bus.outReady = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_illegal();
        test_random();
        test_midop_reset();
`ifdef ALU_OP_DECODER_ILLEGAL_STICKY_EN
        test_sticky();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
